// File: rtl/mcoi_reset_sequencer.sv
// Sequenced multi-domain reset generator: synchronises and debounces reset-request sources,
// then releases domain resets in order with fixed spacing; keeps event count and cause flags.
module mcoi_reset_sequencer #(
   parameter int unsigned          NUM_SRC         = 3,
   parameter logic [NUM_SRC-1:0]   SRC_ACTIVE_HIGH = 3'b011,
   parameter int unsigned          NUM_DOM         = 3,
   parameter int unsigned          FILTER_LEN      = 16,
   parameter int unsigned          HOLDOFF         = 256,
   parameter int unsigned          STAGE_DLY       = 64,
   parameter int unsigned          CNT_W           = 16
) (
   input  logic               clk_ik,
   input  logic               rst_ir,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               clear_i,
   output logic [NUM_DOM-1:0] rst_o,
   output logic               ready_o,
   output logic [NUM_SRC-1:0] cause_o,
   output logic [CNT_W-1:0]   reset_count_o
);

   localparam logic [15:0]        FLT_LAST  = 16'(FILTER_LEN - 1);
   localparam logic [15:0]        HOLDOFF_L = 16'(HOLDOFF);
   localparam logic [15:0]        STAGE_L   = 16'(STAGE_DLY - 1);
   localparam logic [NUM_DOM-1:0] DOM_ONES  = '1;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_QUIET,
      ST_RELEASE,
      ST_RUN
   } state_t;

   state_t             state_q;
   logic [NUM_SRC-1:0] sync1_q;
   logic [NUM_SRC-1:0] sync2_q;
   logic [NUM_SRC-1:0] req_raw;
   logic [NUM_SRC-1:0] req_f_q;
   logic [15:0]        flt_cnt_q [NUM_SRC];
   logic               req;
   logic [15:0]        tmr_q;
   logic [NUM_DOM-1:0] rst_q;
   logic               ready_q;
   logic [NUM_SRC-1:0] cause_q;
   logic [CNT_W-1:0]   cnt_q;

   always_comb begin
      req_raw = sync2_q ~^ SRC_ACTIVE_HIGH;
      req     = |req_f_q;
   end

   // Synchronisers come out of reset holding the "request" level so nothing is released
   // until every source has been seen quiet for a full filter window.
   always_ff @(posedge clk_ik) begin
      if (rst_ir) begin
         sync1_q <= SRC_ACTIVE_HIGH;
         sync2_q <= SRC_ACTIVE_HIGH;
         req_f_q <= '1;
         for (int unsigned i = 0; i < NUM_SRC; i++)
            flt_cnt_q[i] <= '0;
      end else begin
         sync1_q <= src_i;
         sync2_q <= sync1_q;
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req_raw[i] == req_f_q[i]) begin
               flt_cnt_q[i] <= '0;
            end else if (flt_cnt_q[i] == FLT_LAST) begin
               req_f_q[i]   <= ~req_f_q[i];
               flt_cnt_q[i] <= '0;
            end else begin
               flt_cnt_q[i] <= flt_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_ik) begin
      if (rst_ir) begin
         state_q <= ST_HOLD;
         tmr_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
         cause_q <= '0;
         cnt_q   <= '0;
      end else begin
         if (clear_i)
            cause_q <= '0;
         case (state_q)
            ST_HOLD: begin
               rst_q   <= '1;
               ready_q <= 1'b0;
               if (!req) begin
                  state_q <= ST_QUIET;
                  tmr_q   <= HOLDOFF_L;
               end
            end
            ST_QUIET: begin
               if (req) begin
                  state_q <= ST_HOLD;
               end else if (tmr_q == 16'd0) begin
                  state_q <= ST_RELEASE;
                  rst_q   <= DOM_ONES << 1;
                  tmr_q   <= STAGE_L;
               end else begin
                  tmr_q <= tmr_q - 16'd1;
               end
            end
            ST_RELEASE, ST_RUN: begin
               if (req) begin
                  // Reset event; a coinciding clear drops old causes but keeps this one.
                  state_q <= ST_HOLD;
                  rst_q   <= '1;
                  ready_q <= 1'b0;
                  if (cnt_q != '1)
                     cnt_q <= cnt_q + CNT_W'(1);
                  cause_q <= clear_i ? req_f_q : (cause_q | req_f_q);
               end else if (state_q == ST_RELEASE) begin
                  if (tmr_q != 16'd0) begin
                     tmr_q <= tmr_q - 16'd1;
                  end else if (!rst_q[NUM_DOM-1]) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end else begin
                     rst_q <= rst_q << 1;
                     tmr_q <= STAGE_L;
                  end
               end
            end
            default: state_q <= ST_HOLD;
         endcase
      end
   end

   assign rst_o         = rst_q;
   assign ready_o       = ready_q;
   assign cause_o       = cause_q;
   assign reset_count_o = cnt_q;

endmodule

// File: tb/tb_mcoi_reset_sequencer.sv
// Directed bench for mcoi_reset_sequencer; a second instance with a 2-bit event counter
// follows the same stimulus to exercise counter saturation.
module tb_mcoi_reset_sequencer;

   logic        clk_ik = 1'b0;
   logic        rst_ir;
   logic [2:0]  src_i;
   logic        clear_i;
   logic [2:0]  rst_o;
   logic        ready_o;
   logic [2:0]  cause_o;
   logic [15:0] reset_count_o;
   logic [2:0]  sat_rst;
   logic        sat_ready;
   logic [2:0]  sat_cause;
   logic [1:0]  sat_count;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk_ik = ~clk_ik;

   mcoi_reset_sequencer #(
      .NUM_SRC(3), .SRC_ACTIVE_HIGH(3'b011), .NUM_DOM(3),
      .FILTER_LEN(4), .HOLDOFF(8), .STAGE_DLY(16), .CNT_W(16)
   ) dut (
      .clk_ik(clk_ik), .rst_ir(rst_ir), .src_i(src_i), .clear_i(clear_i),
      .rst_o(rst_o), .ready_o(ready_o), .cause_o(cause_o), .reset_count_o(reset_count_o)
   );

   mcoi_reset_sequencer #(
      .NUM_SRC(3), .SRC_ACTIVE_HIGH(3'b011), .NUM_DOM(3),
      .FILTER_LEN(4), .HOLDOFF(8), .STAGE_DLY(16), .CNT_W(2)
   ) u_sat (
      .clk_ik(clk_ik), .rst_ir(rst_ir), .src_i(src_i), .clear_i(clear_i),
      .rst_o(sat_rst), .ready_o(sat_ready), .cause_o(sat_cause), .reset_count_o(sat_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then park on the following falling edge.
   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk_ik);
      @(negedge clk_ik);
   endtask

   task automatic wait_ready(input string tag, input int unsigned budget);
      int unsigned k = 0;
      while (!ready_o && k < budget) begin
         step(1);
         k++;
      end
      check(tag, 32'(ready_o), 32'd1);
   endtask

   initial begin
      int unsigned bad;
      rst_ir  = 1'b1;
      src_i   = 3'b100;
      clear_i = 1'b0;
      step(5);
      check("reset_rst", 32'(rst_o), 32'h7);
      check("reset_ready", 32'(ready_o), 32'd0);
      rst_ir = 1'b0;

      // power-up: filters settle, QUIET entered at edge 7, bit 0 falls at edge 16
      step(15);
      check("pu_hold_rst", 32'(rst_o), 32'h7);
      step(1);
      check("pu_bit0", 32'(rst_o), 32'h6);
      step(15);
      check("pu_bit0_hold", 32'(rst_o), 32'h6);
      step(1);
      check("pu_bit1", 32'(rst_o), 32'h4);
      step(15);
      check("pu_bit1_hold", 32'(rst_o), 32'h4);
      step(1);
      check("pu_bit2", 32'(rst_o), 32'h0);
      check("pu_ready_early", 32'(ready_o), 32'd0);
      step(15);
      check("pu_ready_pre", 32'(ready_o), 32'd0);
      step(1);
      check("pu_ready", 32'(ready_o), 32'd1);
      check("pu_count", 32'(reset_count_o), 32'd0);
      check("pu_cause", 32'(cause_o), 32'd0);

      // glitch shorter than the filter window
      src_i = 3'b101;
      step(3);
      src_i = 3'b100;
      step(12);
      check("gl3_rst", 32'(rst_o), 32'h0);
      check("gl3_ready", 32'(ready_o), 32'd1);
      check("gl3_count", 32'(reset_count_o), 32'd0);

      // 6-cycle request on src 0
      src_i = 3'b101;
      step(6);
      check("gl6_pre_rst", 32'(rst_o), 32'h0);
      src_i = 3'b100;
      step(1);
      check("gl6_rst", 32'(rst_o), 32'h7);
      check("gl6_ready", 32'(ready_o), 32'd0);
      check("gl6_count", 32'(reset_count_o), 32'd1);
      check("gl6_cause", 32'(cause_o), 32'h1);
      step(14);
      check("gl6_quiet_rst", 32'(rst_o), 32'h7);
      step(1);
      check("gl6_rel_bit0", 32'(rst_o), 32'h6);
      wait_ready("gl6_ready_back", 100);

      // active-low source 2 pulled low for 10 cycles
      src_i = 3'b000;
      step(7);
      check("al_rst", 32'(rst_o), 32'h7);
      check("al_count", 32'(reset_count_o), 32'd2);
      check("al_cause", 32'(cause_o), 32'h5);
      check("al_sat_count", 32'(sat_count), 32'd2);
      step(3);
      src_i = 3'b100;
      step(15);
      check("al_quiet_rst", 32'(rst_o), 32'h7);
      step(1);
      check("al_rel_bit0", 32'(rst_o), 32'h6);

      // re-request while in RELEASE with rst_o = 110
      src_i = 3'b110;
      step(6);
      check("mid_pre_rst", 32'(rst_o), 32'h6);
      step(1);
      check("mid_rst", 32'(rst_o), 32'h7);
      check("mid_count", 32'(reset_count_o), 32'd3);
      check("mid_cause", 32'(cause_o), 32'h7);
      check("mid_sat_count", 32'(sat_count), 32'd3);
      src_i = 3'b100;
      step(15);
      check("mid_quiet_rst", 32'(rst_o), 32'h7);
      step(1);
      check("mid_rel_bit0", 32'(rst_o), 32'h6);
      step(15);
      check("mid_bit0_hold", 32'(rst_o), 32'h6);
      step(1);
      check("mid_rel_bit1", 32'(rst_o), 32'h4);
      wait_ready("mid_ready_back", 100);

      // re-request during QUIET: event at edge 7, QUIET from 13, src 0 back high in QUIET
      src_i = 3'b101;
      step(6);
      src_i = 3'b100;
      step(1);
      check("qt_rst", 32'(rst_o), 32'h7);
      check("qt_count", 32'(reset_count_o), 32'd4);
      bad = 0;
      for (int unsigned i = 8; i <= 34; i++) begin
         step(1);
         if (rst_o !== 3'b111 || ready_o !== 1'b0)
            bad++;
         if (i == 13)
            src_i = 3'b101;
         if (i == 19)
            src_i = 3'b100;
      end
      check("qt_hold_cycles", 32'(bad), 32'd0);
      check("qt_count_same", 32'(reset_count_o), 32'd4);
      step(1);
      check("qt_rel_bit0", 32'(rst_o), 32'h6);
      wait_ready("qt_ready_back", 100);

      // clear coinciding with an event: cause becomes the new req_f only
      check("clr_cause_before", 32'(cause_o), 32'h7);
      src_i = 3'b101;
      step(6);
      clear_i = 1'b1;
      step(1);
      clear_i = 1'b0;
      check("clr_evt_cause", 32'(cause_o), 32'h1);
      check("clr_evt_count", 32'(reset_count_o), 32'd5);
      check("sat_hold", 32'(sat_count), 32'd3);
      src_i = 3'b100;
      wait_ready("clr_ready_back", 100);
      clear_i = 1'b1;
      step(1);
      clear_i = 1'b0;
      check("clr_alone_cause", 32'(cause_o), 32'h0);
      check("end_rst", 32'(rst_o), 32'h0);
      check("end_count", 32'(reset_count_o), 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
